// File: rtl/offchip_mem_pkg.sv
// Shared constants and FSM state type for the off-chip data memory model.
package offchip_mem_pkg;

    localparam int unsigned LINE_BITS   = 256;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned ADDR_BITS   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage : offchip_mem_pkg

// File: rtl/offchip_mem_array.sv
// DEPTH x 256-bit line store, single read/write port, write-through read register.
module offchip_mem_array
    import offchip_mem_pkg::*;
#(
    parameter  int unsigned DEPTH = 512,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     addr_i,
    input  logic [LINE_BITS-1:0] wdata_i,
    output logic [LINE_BITS-1:0] rdata_o
);

    logic [LINE_BITS-1:0] mem [DEPTH];

    // Storage update; contents deliberately have no reset.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    // Output register: read data, or echo of the line being written; holds otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (en_i) begin
            rdata_o <= we_i ? wdata_i : mem[addr_i];
        end
    end

endmodule : offchip_mem_array

// File: rtl/offchip_data_memory.sv
// Off-chip main memory responder: one 256-bit line access per request after a
// fixed latency, completed with a one-cycle ack.
// Optional: define OFFCHIP_MEM_CHECK_EN to add the sticky protocol error output err_o.
module offchip_data_memory
    import offchip_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 write_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o
`ifdef OFFCHIP_MEM_CHECK_EN
    ,
    output logic                 err_o
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 accept_c;
    logic                 access_c;
    logic                 ack_d;

    logic                 lat_write_q;
    logic [IDX_W-1:0]     lat_idx_q;
    logic [LINE_BITS-1:0] lat_data_q;

    // State and latency counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_o   <= ack_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, one ACK cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        access_c = 1'b0;
        ack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    accept_c = 1'b1;
                    cnt_d    = CNT_W'(LATENCY - 1);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    access_c = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the request at acceptance; the access only ever uses these copies.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_write_q <= 1'b0;
            lat_idx_q   <= '0;
            lat_data_q  <= '0;
        end else if (accept_c) begin
            lat_write_q <= write_i;
            lat_idx_q   <= addr_i[OFFSET_BITS +: IDX_W];
            lat_data_q  <= data_i;
        end
    end

    offchip_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (access_c),
        .we_i    (lat_write_q),
        .addr_i  (lat_idx_q),
        .wdata_i (lat_data_q),
        .rdata_o (data_o)
    );

`ifdef OFFCHIP_MEM_CHECK_EN
    logic [ADDR_BITS-1:0] lat_addr_q;

    // Full address copy so any address change during BUSY is detected.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_addr_q <= '0;
        end else if (accept_c) begin
            lat_addr_q <= addr_i;
        end
    end

    // Sticky error when the initiator does not hold the request stable while BUSY.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (state_q == BUSY &&
                     (!req_i || write_i != lat_write_q || addr_i != lat_addr_q)) begin
            err_o <= 1'b1;
        end
    end
`else
    // Offset and high address bits play no part in the line index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[ADDR_BITS-1:OFFSET_BITS+IDX_W], addr_i[OFFSET_BITS-1:0]};
`endif

endmodule : offchip_data_memory

// File: tb/tb_offchip_data_memory.sv
module tb_offchip_data_memory;
    import offchip_mem_pkg::*;

    localparam int unsigned LATENCY = 10;
    localparam int unsigned DEPTH   = 512;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 req_i;
    logic                 write_i;
    logic [31:0]          addr_i;
    logic [255:0]         data_i;
    logic                 ack_o;
    logic [255:0]         data_o;
`ifdef OFFCHIP_MEM_CHECK_EN
    logic                 err_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] exp_mem [DEPTH];

    always #5 clk_i = ~clk_i;

    offchip_data_memory #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) u_dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .write_i (write_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .data_o  (data_o)
`ifdef OFFCHIP_MEM_CHECK_EN
        ,
        .err_o   (err_o)
`endif
    );

    typedef struct {
        bit           write;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [255:0] exp;
        string        name;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned line_of(input logic [31:0] a);
        return (int'(a) >>> 0) >= 0 ? ((a / 32) % DEPTH) : 0;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Issue one request starting at a negedge; return at the negedge after the ack.
    task automatic req_cycle(input bit w, input logic [31:0] a, input logic [255:0] d,
                             input logic [255:0] exp_d, input bit hold, input string name,
                             output time t_ack);
        int k;
        req_i   = 1'b1;
        write_i = w;
        addr_i  = a;
        data_i  = d;
        k = 0;
        for (int i = 1; i <= int'(LATENCY) + 6; i++) begin
            @(negedge clk_i);
            k = i;
            if (ack_o) break;
        end
        t_ack = $time;
        check({name, " latency"}, 256'(k), 256'(LATENCY + 1));
        check({name, " data"}, data_o, exp_d);
        if (!hold) req_i = 1'b0;
        @(negedge clk_i);
        check({name, " single ack"}, 256'(ack_o), 256'(0));
    endtask

    // Model-driven access: expected data comes from the reference line array.
    task automatic model_req(input bit w, input logic [31:0] a, input logic [255:0] d,
                             input bit hold, input string name, output time t_ack);
        int unsigned idx;
        logic [255:0] exp_d;
        idx = (a / 32) % DEPTH;
        exp_d = w ? d : exp_mem[idx];
        if (w) exp_mem[idx] = d;
        req_cycle(w, a, d, exp_d, hold, name, t_ack);
    endtask

    initial begin
        vec_t vecs [6];
        time  t, t_prev;
        int   ack_cnt;
        logic [255:0] line7_new;

        rst_i   = 1'b1;
        req_i   = 1'b0;
        write_i = 1'b0;
        addr_i  = '0;
        data_i  = '0;

        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [255:0] p;
            p = {8{32'(i) ^ 32'hC0DE_0000}};
            exp_mem[i] = p;
            u_dut.u_array.mem[i] = p;
        end
        exp_mem[3] = {32{8'hA5}};
        u_dut.u_array.mem[3] = {32{8'hA5}};

        repeat (2) @(negedge clk_i);
        check("reset ack", 256'(ack_o), 256'(0));
        check("reset data", data_o, 256'(0));
        check("reset state", 256'(u_dut.state_q), 256'(IDLE));
`ifdef OFFCHIP_MEM_CHECK_EN
        check("reset err", 256'(err_o), 256'(0));
`endif
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed table: latency, write/read-back, offset ignore and wrap.
        vecs[0] = '{1'b0, 32'h0000_0060, 256'h0, {32{8'hA5}}, "read line3"};
        vecs[1] = '{1'b1, 32'h0000_0080, {8{32'h1234_5678}}, {8{32'h1234_5678}}, "write 0x80"};
        vecs[2] = '{1'b0, 32'h0000_0080, 256'h0, {8{32'h1234_5678}}, "read 0x80"};
        vecs[3] = '{1'b1, 32'h0000_4020, {8{32'hDEAD_BEEF}}, {8{32'hDEAD_BEEF}}, "write wrap"};
        vecs[4] = '{1'b0, 32'h0000_003F, 256'h0, {8{32'hDEAD_BEEF}}, "read offset"};
        vecs[5] = '{1'b0, 32'h0000_0020, 256'h0, {8{32'hDEAD_BEEF}}, "read line1"};
        for (int i = 0; i < 6; i++) begin
            req_cycle(vecs[i].write, vecs[i].addr, vecs[i].data, vecs[i].exp,
                      (i == 1), vecs[i].name, t);
            if (vecs[i].write) exp_mem[(vecs[i].addr / 32) % DEPTH] = vecs[i].data;
        end

        // Reset during BUSY aborts the write to line 7.
        line7_new = {8{32'h7777_0000}};
        req_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_00E0; data_i = line7_new;
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("abort ack", 256'(ack_o), 256'(0));
        check("abort data", data_o, 256'(0));
        check("abort state", 256'(u_dut.state_q), 256'(IDLE));
        @(negedge clk_i);
        rst_i = 1'b0;
        req_i = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < int'(LATENCY) + 3; i++) begin
            @(negedge clk_i);
            if (ack_o) ack_cnt++;
        end
        check("abort no ack", 256'(ack_cnt), 256'(0));
        model_req(1'b0, 32'h0000_00E0, '0, 1'b0, "line7 kept", t);

        // Back-to-back with req held: one ack per LATENCY+2 cycles.
        model_req(1'b1, 32'h0000_0100, rand_line(), 1'b1, "b2b0", t_prev);
        for (int i = 1; i < 4; i++) begin
            model_req(i[0], 32'h0000_0100, rand_line(), 1'b1, "b2b", t);
            check("b2b period", 256'(t - t_prev), 256'((LATENCY + 2) * 10));
            t_prev = t;
        end
        req_i = 1'b0;
        @(negedge clk_i);

        // Random traffic on a few lines with random high/offset bits.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = $urandom();
            a[13:5] = 9'($urandom_range(0, 15));
            model_req(bit'($urandom_range(0, 1)), a, rand_line(),
                      bit'($urandom_range(0, 1)), "rand", t);
        end
        req_i = 1'b0;
        @(negedge clk_i);

`ifdef OFFCHIP_MEM_CHECK_EN
        // Address change in BUSY: sticky error, original line still returned.
        check("err clean", 256'(err_o), 256'(0));
        req_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0040; data_i = '0;
        repeat (3) @(negedge clk_i);
        addr_i = 32'h0000_0100;
        ack_cnt = 0;
        for (int i = 0; i < int'(LATENCY) + 4; i++) begin
            @(negedge clk_i);
            if (ack_o) begin ack_cnt = 1; break; end
        end
        check("err ack", 256'(ack_cnt), 256'(1));
        check("err data", data_o, exp_mem[2]);
        check("err set", 256'(err_o), 256'(1));
        req_i = 1'b0;
        @(negedge clk_i);
        model_req(1'b0, 32'h0000_0060, '0, 1'b0, "after err", t);
        check("err sticky", 256'(err_o), 256'(1));
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("err cleared", 256'(err_o), 256'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_offchip_data_memory
